fw_cmd_decoder: RTL and testbench

- Host-facing command decoder that sits directly upstream of the IP test engines (fw_ip1/fw_ip2).
- Consumes 32-bit host write words split as {device_id[31:28], op_code[27:24], body[23:0]} and decodes the 16 op codes.
- Maintains the static, array and execute configuration registers, the 32-bit firmware status word, read-back, firmware soft reset, and the start/done handshake with the test state machines.

---
 rtl/fw_cmd_decoder.sv | 140 ++++++++++++++
 tb/tb_fw_cmd_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fw_cmd_decoder.sv
// fw_cmd_decoder: host command decoder, config/status registers and test start/done handshake.
// Optional busy watchdog is built when FW_CMD_DECODER_WATCHDOG_EN is defined.
module fw_cmd_decoder #(
  parameter logic [3:0]  FIRMWARE_ID      = 4'h2,
  parameter int          TEST_NUM_LSB     = 12,
  parameter int          RST_PULSE_CYCLES = 8,
  parameter logic [31:0] WDOG_CYCLES      = 32'd100_000_000
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst,
  input  logic        fw_cmd_valid,
  input  logic [31:0] fw_cmd_data,
  output logic        fw_rd_valid,
  output logic [31:0] fw_rd_data,
  output logic [23:0] fw_cfg_static_0,
  output logic [23:0] fw_cfg_static_1,
  output logic [23:0] fw_cfg_array_0,
  output logic [23:0] fw_cfg_array_1,
  output logic [23:0] fw_cfg_array_2,
  input  logic [23:0] fw_data_array_0,
  input  logic [23:0] fw_data_array_1,
  output logic [23:0] fw_execute_cfg,
  output logic [3:0]  fw_test_start,
  input  logic [3:0]  fw_test_done,
  output logic [31:0] fw_status,
  output logic        fw_rst_fw
);
  typedef enum logic [1:0] {IDLE, RST_PULSE, BUSY} state_t;
  localparam logic [3:0] OP_RST  = 4'h1;
  localparam logic [3:0] OP_WS0  = 4'h2;
  localparam logic [3:0] OP_RS0  = 4'h3;
  localparam logic [3:0] OP_WS1  = 4'h4;
  localparam logic [3:0] OP_RS1  = 4'h5;
  localparam logic [3:0] OP_WA0  = 4'h6;
  localparam logic [3:0] OP_RA0  = 4'h7;
  localparam logic [3:0] OP_WA1  = 4'h8;
  localparam logic [3:0] OP_RA1  = 4'h9;
  localparam logic [3:0] OP_WA2  = 4'hA;
  localparam logic [3:0] OP_RA2  = 4'hB;
  localparam logic [3:0] OP_RD0  = 4'hC;
  localparam logic [3:0] OP_RD1  = 4'hD;
  localparam logic [3:0] OP_CLR  = 4'hE;
  localparam logic [3:0] OP_EXEC = 4'hF;
  state_t state, state_nxt;
  logic [7:0] pcnt;
  logic [3:0] op, tn;
  logic [23:0] body, rd_val;
  logic [4:0] sb;
  logic [31:0] status_nxt;
  logic acc, tn_ok, exec_ok, done_hit, wdog_hit, wdog_exit, rst_entry, rd_en;
  assign op = fw_cmd_data[27:24];
  assign body = fw_cmd_data[23:0];
  assign acc = fw_cmd_valid && fw_cmd_data[31:28] == FIRMWARE_ID && state != RST_PULSE;
  assign tn = body[TEST_NUM_LSB +: 4];
  assign tn_ok = tn != 4'd0 && (tn & (tn - 4'd1)) == 4'd0;
  assign exec_ok = state == IDLE && tn_ok;
  assign done_hit = |(fw_test_done & fw_execute_cfg[TEST_NUM_LSB +: 4]);
  assign sb = {1'b0, op} - 5'd1;
  assign rd_en = acc && ((op[0] && op >= OP_RS0 && op <= OP_RD1) || op == OP_RD0);
  assign rst_entry = state != RST_PULSE && state_nxt == RST_PULSE;
  assign fw_rst_fw = state == RST_PULSE;
  assign rd_val = op == OP_RS0 ? fw_cfg_static_0 :
                  op == OP_RS1 ? fw_cfg_static_1 :
                  op == OP_RA0 ? fw_cfg_array_0 :
                  op == OP_RA1 ? fw_cfg_array_1 :
                  op == OP_RA2 ? fw_cfg_array_2 :
                  op == OP_RD0 ? fw_data_array_0 : fw_data_array_1;
`ifdef FW_CMD_DECODER_WATCHDOG_EN
  logic [31:0] wcnt;
  always_ff @(posedge fw_axi_clk)
    wcnt <= (fw_rst || state != BUSY) ? 32'd0 : wcnt + 32'd1;
  assign wdog_hit = state == BUSY && wcnt == WDOG_CYCLES - 32'd1;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_hit = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    wdog_exit = 1'b0;
    if (state == RST_PULSE) state_nxt = pcnt == 8'd0 ? IDLE : RST_PULSE;
    else if (acc && op == OP_RST) state_nxt = RST_PULSE;
    else if (acc && op == OP_EXEC && exec_ok) state_nxt = BUSY;
    else if (state == BUSY && (done_hit || wdog_hit)) begin
      state_nxt = IDLE;
      wdog_exit = !done_hit;
    end
  end
  // done bits are ORed in last so a same-cycle clear or soft reset cannot drop them
  always_comb begin
    status_nxt = fw_status;
    if (acc && op == OP_CLR) status_nxt = '0;
    else if (acc && op >= OP_WS0 && op <= OP_RD1) status_nxt[sb] = 1'b1;
    else if (acc && op == OP_EXEC) begin
      status_nxt[13] = status_nxt[13] | exec_ok;
      status_nxt[31] = status_nxt[31] | !exec_ok;
    end
    if (rst_entry) status_nxt = 32'd1;
    if (wdog_exit) status_nxt[30] = 1'b1;
    status_nxt[17:14] = status_nxt[17:14] | fw_test_done;
  end
  always_ff @(posedge fw_axi_clk) begin
    if (fw_rst) begin
      state <= IDLE;
      pcnt <= '0;
      fw_status <= '0;
      fw_rd_valid <= 1'b0;
      fw_rd_data <= '0;
      fw_test_start <= '0;
      fw_cfg_static_0 <= '0;
      fw_cfg_static_1 <= '0;
      fw_cfg_array_0 <= '0;
      fw_cfg_array_1 <= '0;
      fw_cfg_array_2 <= '0;
      fw_execute_cfg <= '0;
    end else begin
      state <= state_nxt;
      fw_status <= status_nxt;
      fw_rd_valid <= rd_en;
      if (rd_en) fw_rd_data <= {fw_cmd_data[31:24], rd_val};
      fw_test_start <= (acc && op == OP_EXEC && exec_ok) ? tn : 4'd0;
      pcnt <= rst_entry ? 8'(RST_PULSE_CYCLES - 1) : (state == RST_PULSE ? pcnt - 8'd1 : pcnt);
      if (rst_entry) begin
        fw_cfg_static_0 <= '0;
        fw_cfg_static_1 <= '0;
        fw_cfg_array_0 <= '0;
        fw_cfg_array_1 <= '0;
        fw_cfg_array_2 <= '0;
        fw_execute_cfg <= '0;
      end else if (acc) begin
        if (op == OP_WS0) fw_cfg_static_0 <= body;
        if (op == OP_WS1) fw_cfg_static_1 <= body;
        if (op == OP_WA0) fw_cfg_array_0 <= body;
        if (op == OP_WA1) fw_cfg_array_1 <= body;
        if (op == OP_WA2) fw_cfg_array_2 <= body;
        if (op == OP_EXEC && exec_ok) fw_execute_cfg <= body;
      end
    end
  end
endmodule

// File: tb/tb_fw_cmd_decoder.sv
// tb_fw_cmd_decoder: directed test-plan checks plus randomized traffic against a behavioural model.
module tb_fw_cmd_decoder;
  localparam logic [3:0] FW_ID = 4'h2;
  localparam int TN = 12;
  localparam int RST_N = 8;
  logic fw_axi_clk = 1'b0;
  logic fw_rst = 1'b1;
  logic fw_cmd_valid = 1'b0;
  logic [31:0] fw_cmd_data = '0;
  logic fw_rd_valid, fw_rst_fw;
  logic [31:0] fw_rd_data, fw_status;
  logic [23:0] fw_cfg_static_0, fw_cfg_static_1, fw_cfg_array_0, fw_cfg_array_1, fw_cfg_array_2;
  logic [23:0] fw_data_array_0 = '0, fw_data_array_1 = '0, fw_execute_cfg;
  logic [3:0] fw_test_start, fw_test_done = '0;
  int total = 0, passed = 0;
  bit run = 0;

  fw_cmd_decoder #(.FIRMWARE_ID(FW_ID), .TEST_NUM_LSB(TN), .RST_PULSE_CYCLES(RST_N)) dut (
    .fw_axi_clk(fw_axi_clk), .fw_rst(fw_rst), .fw_cmd_valid(fw_cmd_valid), .fw_cmd_data(fw_cmd_data),
    .fw_rd_valid(fw_rd_valid), .fw_rd_data(fw_rd_data),
    .fw_cfg_static_0(fw_cfg_static_0), .fw_cfg_static_1(fw_cfg_static_1),
    .fw_cfg_array_0(fw_cfg_array_0), .fw_cfg_array_1(fw_cfg_array_1), .fw_cfg_array_2(fw_cfg_array_2),
    .fw_data_array_0(fw_data_array_0), .fw_data_array_1(fw_data_array_1),
    .fw_execute_cfg(fw_execute_cfg), .fw_test_start(fw_test_start), .fw_test_done(fw_test_done),
    .fw_status(fw_status), .fw_rst_fw(fw_rst_fw));

  always #5 fw_axi_clk = ~fw_axi_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  // model: mode 0 idle, 1 soft-reset pulse, 2 test running
  logic [23:0] m_cfg [5];
  logic [23:0] m_exec;
  logic [31:0] m_status, m_rdd;
  logic [3:0] m_start;
  logic m_rdv;
  int m_mode, m_left;

  always @(posedge fw_axi_clk) begin
    int op, pm;
    logic [23:0] body;
    logic [3:0] tn;
    if (fw_rst) begin
      foreach (m_cfg[i]) m_cfg[i] = '0;
      m_exec = '0; m_status = '0; m_rdd = '0; m_start = '0; m_rdv = 0; m_mode = 0; m_left = 0;
    end else begin
      pm = m_mode;
      m_start = '0;
      m_rdv = 0;
      op = int'(fw_cmd_data[27:24]);
      body = fw_cmd_data[23:0];
      tn = body[TN +: 4];
      if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end else if (fw_cmd_valid && fw_cmd_data[31:28] == FW_ID) begin
        if (op == 1) begin
          foreach (m_cfg[i]) m_cfg[i] = '0;
          m_exec = '0; m_status = 32'd1; m_mode = 1; m_left = RST_N;
        end else if (op >= 2 && op <= 10 && op % 2 == 0) begin
          m_cfg[(op - 2) / 2] = body;
          m_status[op - 1] = 1'b1;
        end else if (op >= 3 && op <= 13) begin
          m_rdv = 1;
          m_rdd = {fw_cmd_data[31:24], op == 12 ? fw_data_array_0 : op == 13 ? fw_data_array_1 : m_cfg[(op - 3) / 2]};
          m_status[op - 1] = 1'b1;
        end else if (op == 14) m_status = '0;
        else if (op == 15) begin
          if (m_mode == 0 && $countones(tn) == 1) begin
            m_exec = body; m_start = tn; m_status[13] = 1'b1; m_mode = 2;
          end else m_status[31] = 1'b1;
        end
      end
      if (pm == 2 && m_mode == 2 && (fw_test_done & m_exec[TN +: 4]) != 0) m_mode = 0;
      m_status[17:14] = m_status[17:14] | fw_test_done;
    end
  end

  always @(negedge fw_axi_clk) if (run) begin
    chk("rd_valid", 32'(fw_rd_valid), 32'(m_rdv));
    chk("rd_data", fw_rd_data, m_rdd);
    chk("cfg_static_0", 32'(fw_cfg_static_0), 32'(m_cfg[0]));
    chk("cfg_static_1", 32'(fw_cfg_static_1), 32'(m_cfg[1]));
    chk("cfg_array_0", 32'(fw_cfg_array_0), 32'(m_cfg[2]));
    chk("cfg_array_1", 32'(fw_cfg_array_1), 32'(m_cfg[3]));
    chk("cfg_array_2", 32'(fw_cfg_array_2), 32'(m_cfg[4]));
    chk("execute_cfg", 32'(fw_execute_cfg), 32'(m_exec));
    chk("test_start", 32'(fw_test_start), 32'(m_start));
    chk("status", fw_status, m_status);
    chk("rst_fw", 32'(fw_rst_fw), 32'(m_mode == 1));
  end

  task automatic cmd(input logic [31:0] d);
    @(negedge fw_axi_clk);
    fw_cmd_valid = 1'b1;
    fw_cmd_data = d;
    @(negedge fw_axi_clk);
    fw_cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge fw_axi_clk);
    fw_rst = 1'b0;
    run = 1;
    chk("lit_reset_status", fw_status, 32'h0);
    chk("lit_reset_rstfw", 32'(fw_rst_fw), 32'h0);
    cmd(32'h2200ABCD);
    chk("lit_static0", 32'(fw_cfg_static_0), 32'h00ABCD);
    cmd(32'h23000000);
    chk("lit_rd_valid", 32'(fw_rd_valid), 32'h1);
    chk("lit_rd_data", fw_rd_data, 32'h2300ABCD);
    chk("lit_status_rd", fw_status, 32'h6);
    cmd(32'h42123456);
    chk("lit_filter_rdv", 32'(fw_rd_valid), 32'h0);
    chk("lit_filter_status", fw_status, 32'h6);
    cmd(32'h2F002000);
    chk("lit_exec_cfg", 32'(fw_execute_cfg), 32'h002000);
    chk("lit_exec_start", 32'(fw_test_start), 32'h2);
    chk("lit_exec_status", fw_status, 32'h2006);
    cmd(32'h2F002000);
    chk("lit_busy_exec_start", 32'(fw_test_start), 32'h0);
    chk("lit_busy_exec_status", fw_status, 32'h80002006);
    fw_test_done = 4'b0010;
    @(negedge fw_axi_clk);
    fw_test_done = 4'b0000;
    chk("lit_done_status", fw_status, 32'h8000A006);
    cmd(32'h2E000000);
    cmd(32'h2F003000);
    chk("lit_bad_tn_status", fw_status, 32'h80000000);
    chk("lit_bad_tn_start", 32'(fw_test_start), 32'h0);
    chk("lit_bad_tn_cfg", 32'(fw_execute_cfg), 32'h002000);
    cmd(32'h2F001000);
    chk("lit_exec1_start", 32'(fw_test_start), 32'h1);
    cmd(32'h21000000);
    chk("lit_rst_status", fw_status, 32'h1);
    chk("lit_rst_cfg", 32'(fw_cfg_static_0), 32'h0);
    chk("lit_rst_exec", 32'(fw_execute_cfg), 32'h0);
    n = 0;
    fw_cmd_valid = 1'b1;
    fw_cmd_data = 32'h22111111;
    while (fw_rst_fw && n < 20) begin
      n++;
      @(negedge fw_axi_clk);
      fw_cmd_valid = 1'b0;
    end
    chk("lit_rst_pulse_len", 32'(n), 32'(RST_N));
    chk("lit_rst_drop_cmd", 32'(fw_cfg_static_0), 32'h0);
    fw_cmd_valid = 1'b1;
    fw_cmd_data = 32'h2E000000;
    fw_test_done = 4'b0001;
    @(negedge fw_axi_clk);
    fw_cmd_valid = 1'b0;
    fw_test_done = 4'b0000;
    chk("lit_clear_vs_done", fw_status, 32'h00004000);
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] op, dev;
      logic [23:0] body;
      @(negedge fw_axi_clk);
      op = 4'($urandom_range(0, 15));
      if (op == 4'h1 && $urandom_range(0, 3) != 0) op = 4'h0;
      dev = $urandom_range(0, 9) != 0 ? FW_ID : 4'($urandom);
      body = 24'($urandom);
      if ($urandom_range(0, 9) < 7) body[TN +: 4] = 4'(1 << $urandom_range(0, 3));
      fw_cmd_valid = 1'($urandom_range(0, 1));
      fw_cmd_data = {dev, op, body};
      fw_test_done = $urandom_range(0, 5) == 0 ? 4'($urandom) : 4'h0;
      fw_data_array_0 = 24'($urandom);
      fw_data_array_1 = 24'($urandom);
      fw_rst = $urandom_range(0, 499) == 0;
    end
    @(negedge fw_axi_clk);
    fw_cmd_valid = 1'b0;
    fw_rst = 1'b0;
    fw_test_done = '0;
    @(negedge fw_axi_clk);
    run = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
